mux_n_1_reg: RTL and testbench

- Parametrised N:1 datapath multiplexer with a one-deep registered output stage and valid/ready handshake on every input and on the output.
- Supports explicit select (MODE=0) or round-robin arbitration among valid inputs (MODE=1).
- Used in the pipelined datapath where operand/result sources need registered steering and back-pressure, e.g. result-bus merge ahead of write-back.

---
 rtl/mux_n_1_reg.sv | 131 +++++++++++++
 tb/tb_mux_n_1_reg.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_1_reg.sv
// N:1 registered multiplexer with valid/ready on every input and the output;
// explicit select (MODE=0) or round-robin (MODE=1). MUX_SEL_CHECK_EN enables sel_err.
module mux_n_1_reg #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2,
    parameter int unsigned MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_src,
    output logic                    sel_err
);

    localparam logic [SEL_W:0]   NumInW  = (SEL_W+1)'(NUM_IN);
    localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NUM_IN - 1);

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [SEL_W-1:0] out_src_q;
    logic [SEL_W-1:0] rr_ptr_q;

    logic             sel_in_range;
    logic             load_en;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic             xfer;
    logic [WIDTH-1:0] data_mux;

    assign sel_in_range = ({1'b0, sel} < NumInW);
    assign load_en      = !out_valid_q || out_ready;

    // Round-robin: inputs above the pointer first, then wrap to those at or below it.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        if (MODE == 0) begin
            grant_vld = sel_in_range;
            grant_idx = sel;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!grant_vld && in_valid[i] && (SEL_W'(i) > rr_ptr_q)) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if (!grant_vld && in_valid[i] && (SEL_W'(i) <= rr_ptr_q)) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end
    end

    // rst gates ready so nothing is accepted while the register is being cleared.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = !rst && load_en && grant_vld && (grant_idx == SEL_W'(i));
        end
    end

    assign xfer = |(in_ready & in_valid);

    always_comb begin
        data_mux = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                data_mux = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            rr_ptr_q    <= LastIdx;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= data_mux;
                out_src_q   <= grant_idx;
                rr_ptr_q    <= grant_idx;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

`ifdef MUX_SEL_CHECK_EN
    logic sel_err_d;
    logic sel_err_q;

    assign sel_err_d = (MODE == 0) && !sel_in_range && (|in_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && sel_err_d && !sel_err_q) begin
            $display("WARNING %m: select %0d out of range (NUM_IN=%0d)", sel, NUM_IN);
        end
    end
`endif
`else
    assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_n_1_reg.sv
// Bench for mux_n_1_reg: three instances (MODE=0/N=4, MODE=1/N=4, MODE=0/N=3)
// checked cycle by cycle against a behavioural model.
module tb_mux_n_1_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [127:0] id  [3];
    logic [3:0]   iv  [3];
    logic [1:0]   sl  [3];
    logic         orr [3];

    logic [3:0]  ir0, ir1;
    logic [2:0]  ir2;
    logic [31:0] od0, od1, od2;
    logic        ov0, ov1, ov2;
    logic [1:0]  os0, os1, os2;
    logic        se0, se1, se2;

    logic [3:0]  ir [3];
    logic [31:0] od [3];
    logic        ov [3];
    logic [1:0]  os [3];
    logic        se [3];

    assign ir[0] = ir0;  assign ir[1] = ir1;  assign ir[2] = {1'b0, ir2};
    assign od[0] = od0;  assign od[1] = od1;  assign od[2] = od2;
    assign ov[0] = ov0;  assign ov[1] = ov1;  assign ov[2] = ov2;
    assign os[0] = os0;  assign os[1] = os1;  assign os[2] = os2;
    assign se[0] = se0;  assign se[1] = se1;  assign se[2] = se2;

    mux_n_1_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(0)) u_sel4 (
        .clk(clk), .rst(rst), .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir0),
        .sel(sl[0]), .out_data(od0), .out_valid(ov0), .out_ready(orr[0]),
        .out_src(os0), .sel_err(se0)
    );

    mux_n_1_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(1)) u_rr4 (
        .clk(clk), .rst(rst), .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir1),
        .sel(sl[1]), .out_data(od1), .out_valid(ov1), .out_ready(orr[1]),
        .out_src(os1), .sel_err(se1)
    );

    mux_n_1_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .MODE(0)) u_sel3 (
        .clk(clk), .rst(rst), .in_data(id[2][95:0]), .in_valid(iv[2][2:0]), .in_ready(ir2),
        .sel(sl[2]), .out_data(od2), .out_valid(ov2), .out_ready(orr[2]),
        .out_src(os2), .sel_err(se2)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state per instance.
    int          nin  [3] = '{4, 4, 3};
    int          mode [3] = '{0, 1, 0};
    bit          mv   [3];
    logic [31:0] md   [3];
    int          ms   [3];
    int          mp   [3];
    bit          me   [3];

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            mv[k] = 0; md[k] = '0; ms[k] = 0; mp[k] = nin[k] - 1; me[k] = 0;
        end
    endfunction

    function automatic int grant_of(int d, logic [1:0] s, logic [3:0] v);
        if (mode[d] == 0) return (int'(s) < nin[d]) ? int'(s) : -1;
        for (int k = 1; k <= nin[d]; k++) begin
            int idx;
            idx = (mp[d] + k) % nin[d];
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock on instance d; the other instances are idled (no valid, no ready).
    task automatic cycle(input int d, input logic [1:0] s, input logic [3:0] v,
                         input logic o, input logic [127:0] data);
        int         g;
        logic [3:0] exp_rdy;
        bit         load, xfer, exp_err;
        for (int k = 0; k < 3; k++) begin
            if (k != d) begin iv[k] = '0; orr[k] = 1'b0; end
        end
        sl[d] = s; iv[d] = v; orr[d] = o; id[d] = data;
        #1;
        load    = !mv[d] || o;
        g       = grant_of(d, s, v);
        exp_rdy = (load && g >= 0) ? 4'(1 << g) : 4'b0000;
        checks++;
        if (ir[d] !== exp_rdy) begin
            errors++;
            $display("FAIL in_ready dut%0d: got %b expected %b", d, ir[d], exp_rdy);
        end
        xfer    = load && (g >= 0) && v[g];
        exp_err = 0;
`ifdef MUX_SEL_CHECK_EN
        exp_err = (mode[d] == 0) && (int'(s) >= nin[d]) && (v != 0);
`endif
        @(posedge clk);
        if (xfer) begin
            mv[d] = 1; md[d] = data[g*32 +: 32]; ms[d] = g; mp[d] = g;
        end else if (mv[d] && o) begin
            mv[d] = 0;
        end
        for (int k = 0; k < 3; k++) me[k] = (k == d) ? exp_err : 1'b0;
        #1;
        checks++;
        if (ov[d] !== mv[d]) begin
            errors++;
            $display("FAIL out_valid dut%0d: got %b expected %b", d, ov[d], mv[d]);
        end
        checks++;
        if (od[d] !== md[d]) begin
            errors++;
            $display("FAIL out_data dut%0d: got %h expected %h", d, od[d], md[d]);
        end
        checks++;
        if (int'(os[d]) != ms[d] || $isunknown(os[d])) begin
            errors++;
            $display("FAIL out_src dut%0d: got %0d expected %0d", d, os[d], ms[d]);
        end
        checks++;
        if (se[d] !== me[d]) begin
            errors++;
            $display("FAIL sel_err dut%0d: got %b expected %b", d, se[d], me[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            iv[k] = 4'b1111; orr[k] = 1'b1; sl[k] = 2'd1; id[k] = rnd128();
        end
        model_reset();
        #3;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || od[k] !== 32'h0 || os[k] !== 2'd0 || se[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got v=%b d=%h s=%0d e=%b expected all 0",
                         k, ov[k], od[k], os[k], se[k]);
            end
            checks++;
            if (ir[k] !== 4'b0000) begin
                errors++;
                $display("FAIL reset_in_ready dut%0d: got %b expected 0000", k, ir[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin iv[k] = '0; orr[k] = 1'b0; sl[k] = '0; end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed_sel();
        cycle(0, 2'd2, 4'b0100, 1'b1, {32'h0, 32'hDEADBEEF, 64'h0});
        checks++;
        if (od[0] !== 32'hDEADBEEF || os[0] !== 2'd2 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL directed_sel: got v=%b d=%h s=%0d expected 1 deadbeef 2",
                     ov[0], od[0], os[0]);
        end
        cycle(0, 2'd0, 4'b0000, 1'b1, rnd128());
    endtask

    task automatic test_back_pressure();
        cycle(0, 2'd0, 4'b0001, 1'b1, {96'h0, 32'h11111111});
        for (int k = 0; k < 3; k++) begin
            cycle(0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b0, rnd128());
            checks++;
            if (od[0] !== 32'h11111111 || ov[0] !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: got v=%b d=%h expected 1 11111111", ov[0], od[0]);
            end
        end
        cycle(0, 2'd1, 4'b0010, 1'b1, {64'h0, 32'h22222222, 32'h0});
        checks++;
        if (od[0] !== 32'h22222222 || ov[0] !== 1'b1) begin
            errors++;
            $display("FAIL no_bubble: got v=%b d=%h expected 1 22222222", ov[0], od[0]);
        end
        cycle(0, 2'd1, 4'b0000, 1'b1, rnd128());
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 8; k++) begin
            cycle(1, 2'd0, 4'b1111, 1'b1, rnd128());
            checks++;
            if (int'(os[1]) != k % 4) begin
                errors++;
                $display("FAIL rr_all step %0d: got %0d expected %0d", k, os[1], k % 4);
            end
        end
        for (int k = 0; k < 4; k++) begin
            cycle(1, 2'd0, 4'b1010, 1'b1, rnd128());
            checks++;
            if (int'(os[1]) != ((k % 2 == 0) ? 1 : 3)) begin
                errors++;
                $display("FAIL rr_sparse step %0d: got %0d expected %0d",
                         k, os[1], (k % 2 == 0) ? 1 : 3);
            end
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1, 2'd2, 4'b1000, 1'b1, rnd128());
            checks++;
            if (os[1] !== 2'd3) begin
                errors++;
                $display("FAIL rr_single step %0d: got %0d expected 3", k, os[1]);
            end
        end
        cycle(1, 2'd0, 4'b0000, 1'b1, rnd128());
    endtask

    task automatic test_sel_range();
        for (int k = 0; k < 3; k++) begin
            cycle(2, 2'd3, 4'b0111, 1'b1, rnd128());
            checks++;
            if (ov[2] !== 1'b0) begin
                errors++;
                $display("FAIL sel_out_of_range: got out_valid %b expected 0", ov[2]);
            end
        end
        cycle(2, 2'd3, 4'b0000, 1'b1, rnd128());
    endtask

    task automatic test_random();
        for (int d = 0; d < 3; d++) begin
            for (int k = 0; k < 150; k++) begin
                cycle(d, 2'($urandom_range(0, 3)),
                      4'($urandom_range(0, 15)) & ((d == 2) ? 4'b0111 : 4'b1111),
                      ($urandom_range(0, 3) != 0), rnd128());
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1, 2'd0, 4'b0110, 1'b0, rnd128());
        cycle(1, 2'd0, 4'b0110, 1'b0, rnd128());
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (ov[1] !== 1'b0 || od[1] !== 32'h0 || os[1] !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b d=%h s=%0d expected 0 0 0", ov[1], od[1], os[1]);
        end
        checks++;
        if (ir[1] !== 4'b0000) begin
            errors++;
            $display("FAIL reset_in_ready_mid: got %b expected 0000", ir[1]);
        end
        model_reset();
        rst = 1'b0;
        cycle(1, 2'd0, 4'b1111, 1'b1, rnd128());
        checks++;
        if (os[1] !== 2'd0 || ov[1] !== 1'b1) begin
            errors++;
            $display("FAIL rr_after_reset: got v=%b s=%0d expected 1 0", ov[1], os[1]);
        end
    endtask

    initial begin
        test_reset();
        test_directed_sel();
        test_back_pressure();
        test_round_robin();
        test_sel_range();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
